// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - control-register and pin-drive bundle for the PWM peripheral
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    // Register-file side: drives the control registers, observes the pins.
    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    // Peripheral side: consumes the control registers, drives the pins.
    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin static/PWM output driver with prescaler and shadowed duty
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13,
    parameter int unsigned DIV_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pwm_peripheral_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic [15:0]      out_q, out_d;
    logic             ps_q, ps_d;

    logic             tick;
    logic             wrap;
    logic             pwm_hi;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // One PWM step per CLK_DIV clocks; a period ends when the last step of count 255 completes.
    assign tick = (presc_q == DIV_LAST);
    assign wrap = tick && (cnt_q == 8'hFF);

    // Compare against the shadowed duty so a mid-period write cannot glitch the waveform;
    // 0xFF is special-cased so full scale really means never low.
    assign pwm_hi = (duty_q == 8'hFF) || (cnt_q < duty_q);

    // Next-state: prescaler, period counter, duty shadow, period marker and pin drive.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        duty_d  = wrap ? bus.pwm_duty_cycle : duty_q;
        ps_d    = wrap;
        // Disabled pins are low; enabled static pins are high; enabled PWM pins follow pwm_hi.
        out_d   = en_out & (~en_pwm | {16{pwm_hi}});
    end

    // State registers; reset clears everything immediately so no partial period survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= 8'd0;
            duty_q  <= 8'h00;
            out_q   <= 16'h0000;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            out_q   <= out_d;
            ps_q    <= ps_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - randomized self-checking bench for pwm_peripheral against a time-based model
module tb_pwm_peripheral;
    localparam int D   = 4;
    localparam int PER = 256 * D;

    logic clk;
    logic rst;
    pwm_peripheral_if bus();

    pwm_peripheral #(.CLK_DIV(D), .DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          n       = 0;
    logic [7:0]  duty_m  = 8'h00;
    logic [15:0] exp_out = 16'h0000;
    logic        exp_ps  = 1'b0;

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
    endtask

    // Model: after n clean edges, step index is n/D; duty in force was loaded at the last multiple of PER.
    task automatic step();
        logic [7:0]  pd;
        logic [7:0]  pc;
        logic        hi;
        logic [15:0] eo;
        logic [15:0] ep;
        pd = duty_m;
        pc = 8'((n / D) % 256);
        @(posedge clk);
        eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
        ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
        if (rst) begin
            n = 0; duty_m = 8'h00; exp_out = 16'h0000; exp_ps = 1'b0;
        end else begin
            n++;
            exp_ps = (n % PER == 0);
            if (exp_ps) duty_m = bus.pwm_duty_cycle;
            hi = (pd == 8'hFF) || (pc < pd);
            exp_out = eo & (~ep | {16{hi}});
        end
        #1;
        vectors++;
        assert (bus.out === exp_out) else begin
            errors++;
            $error("FAIL out n=%0d observed=%h expected=%h", n, bus.out, exp_out);
        end
        vectors++;
        assert (bus.period_start === exp_ps) else begin
            errors++;
            $error("FAIL period_start n=%0d observed=%b expected=%b", n, bus.period_start, exp_ps);
        end
    endtask

    task automatic wait_ps(output int steps);
        bit found;
        found = 0;
        steps = 0;
        for (int k = 0; k < 2 * PER + 8; k++) begin
            step();
            steps++;
            if (bus.period_start === 1'b1) begin found = 1; break; end
        end
        vectors++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_ps timeout observed=0 expected=1");
        end
    endtask

    // Runs exactly one period right after a period_start sample; optionally rewrites duty mid-way.
    task automatic count_period(input int exp_hi, input int change_at, input logic [7:0] new_duty);
        int hi_cnt;
        int ps_cnt;
        hi_cnt = 0;
        ps_cnt = 0;
        for (int k = 0; k < PER; k++) begin
            if (k == change_at) bus.pwm_duty_cycle = new_duty;
            step();
            if (bus.out[0] === 1'b1) hi_cnt++;
            if (bus.period_start === 1'b1) ps_cnt++;
        end
        vectors++;
        assert (hi_cnt == exp_hi) else begin
            errors++;
            $error("FAIL high_count observed=%0d expected=%0d", hi_cnt, exp_hi);
        end
        vectors++;
        assert (ps_cnt == 1) else begin
            errors++;
            $error("FAIL ps_width observed=%0d expected=1", ps_cnt);
        end
    endtask

    initial begin
        int steps;
        // 1: reset with everything asserted, then time to first period marker
        rst = 1'b1;
        set_en(16'hFFFF, 16'hFFFF);
        bus.pwm_duty_cycle = 8'hFF;
        #1;
        vectors++;
        assert (bus.out === 16'h0000 && bus.period_start === 1'b0) else begin
            errors++;
            $error("FAIL async_reset observed=%h/%b expected=0000/0", bus.out, bus.period_start);
        end
        repeat (3) step();
        rst = 1'b0;
        wait_ps(steps);
        vectors++;
        assert (steps == PER) else begin
            errors++;
            $error("FAIL first_period observed=%0d expected=%0d", steps, PER);
        end

        // 2: static enable behaviour, then random enables
        set_en(16'h00FF, 16'h0000); step();
        set_en(16'hA5FF, 16'h0000); step();
        set_en(16'h0000, 16'hFFFF); step();
        for (int k = 0; k < 24; k++) begin
            set_en(16'($urandom), 16'($urandom));
            bus.pwm_duty_cycle = 8'($urandom);
            step();
        end

        // 3,4: directed duties measured over whole periods
        set_en(16'hFFFF, 16'hFFFF);
        bus.pwm_duty_cycle = 8'h80;
        wait_ps(steps);
        bus.pwm_duty_cycle = 8'h00; count_period(512 * D / 4 * 4 / D * D / 4, -1, 8'h00);
        bus.pwm_duty_cycle = 8'hFF; count_period(0, -1, 8'h00);
        bus.pwm_duty_cycle = 8'h01; count_period(PER, -1, 8'h00);
        bus.pwm_duty_cycle = 8'h40; count_period(1 * D, -1, 8'h00);

        // 5: mid-period rewrite only takes effect at the next period
        count_period(64 * D, PER / 2, 8'hC0);
        count_period(192 * D, -1, 8'h00);

        // random duties and enables per period
        for (int p = 0; p < 4; p++) begin
            logic [7:0] dr;
            dr = 8'($urandom);
            bus.pwm_duty_cycle = dr;
            for (int k = 0; k < PER; k++) begin
                if (k % 97 == 0) set_en(16'($urandom), 16'($urandom));
                if (k == 300) bus.pwm_duty_cycle = 8'($urandom);
                step();
            end
        end

        // 6: asynchronous reset mid-period with pins high
        set_en(16'hFFFF, 16'h0000);
        bus.pwm_duty_cycle = 8'($urandom_range(1, 254));
        repeat (200) step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        assert (bus.out === 16'h0000 && bus.period_start === 1'b0) else begin
            errors++;
            $error("FAIL mid_reset observed=%h/%b expected=0000/0", bus.out, bus.period_start);
        end
        step();
        rst = 1'b0;
        set_en(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < PER + 300; k++) begin
            if (k == 500) bus.pwm_duty_cycle = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register file. Takes the five 8-bit control registers: output enables, PWM enables and duty cycle. Drives 16 registered output pins, each either static or modulated by a shared 8-bit PWM waveform. Contains a clock prescaler, an 8-bit period counter, and a duty shadow register that updates only at period boundaries, giving glitch-free duty changes.

Parameters:
CLK_DIV, 13, prescaler divide ratio; PWM step = CLK_DIV clk cycles, period = 256*CLK_DIV cycles (about 3 kHz at 10 MHz); legal range 1..65535
DIV_W, 16, width of the prescaler counter; must hold CLK_DIV-1

Ports:
clk  input  1  system clock (10 MHz)
rst  input  1  reset, asynchronous, active-high
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM mode enable, pins 7..0
en_reg_pwm_15_8  input  8  PWM mode enable, pins 15..8
pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%
out  output  16  registered pin drive
period_start  output  1  one-cycle pulse, registered, marks first clk of each PWM period

Behaviour:
- Reset (rst high, async): prescaler=0, pwm_cnt=0, duty_sh=0x00, out=16'h0000, period_start=0. Takes effect immediately and independent of clk. First rising clk edge after deassert counts normally.
- Internal en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise.
- Prescaler:
  - Counts 0..CLK_DIV-1, wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
  - CLK_DIV=1 gives tick every cycle.
- pwm_cnt:
  - 8-bit, increments on tick, wraps 255->0 (natural 8-bit overflow).
- Duty shadow:
  - wrap = tick && pwm_cnt==255.
  - On wrap, duty_sh <= pwm_duty_cycle.
  - Changes to pwm_duty_cycle at any other time have no effect until the next wrap.
  - duty_sh stays 0x00 until the first wrap after reset.
- period_start <= wrap. High exactly the one cycle in which pwm_cnt==0 and prescaler==0.
- Waveform: pwm_hi = (duty_sh==8'hFF) | (pwm_cnt < duty_sh).
  - High time per period = duty_sh*CLK_DIV cycles for duty_sh<255.
  - duty_sh=255 is constant high.
  - duty_sh=0 is constant low.
- Output, per pin i, registered each clk:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_hi : 1) : 0.
  - en_out=0 forces low regardless of en_pwm.
- Latency:
  - Enable changes appear on out one clk after sampled.
  - out lags pwm_cnt/duty_sh by one clk.
  - Duty changes appear at the start of the next period.
- Enable registers are not shadowed. Toggling en_pwm mid-period switches the pin between static high and the waveform on the next clk.
- All pins share one counter, so PWM pins are phase-aligned.
- Simultaneous wrap and duty change in the same cycle: the value present on pwm_duty_cycle at that edge is loaded.
- Reset asserted mid-period aborts the period. No partial state survives.

Test Plan:
1. Assert rst for 3 cycles with all inputs 0xFF -> out=0x0000 and period_start=0 during reset. After deassert, first period_start occurs 256*CLK_DIV cycles later.
2. CLK_DIV=4; en_reg_out=0x00FF/0x00, en_pwm=0 -> out=16'h00FF one clk later. Set en_reg_out_15_8=0xA5 -> out=16'hA5FF next clk. Clear en_out with en_pwm=0xFF -> out=0.
3. CLK_DIV=4; all enables 0xFF, duty=0x80 -> from the period_start after the next wrap, every out bit is high 512 of 1024 cycles, one contiguous run starting 1 clk after period_start.
4. duty=0x00 -> out stays 0x0000 over a full period. duty=0xFF -> out stays 0xFFFF with no low cycle across a wrap boundary. duty=0x01 -> high exactly 4 cycles per period.
5. duty 0x40 loaded; write 0xC0 mid-period -> current period keeps 256 high cycles; next period has 768 high cycles. period_start pulse is exactly 1 cycle wide.
6. Assert rst mid-period with PWM pins high -> out drops to 0 before the next clk edge. After release, duty_sh=0 so pins stay low until the first wrap.
